gauss_pair_scaler: RTL and testbench

- Parametrised, pipelined successor to the single-bit Gaussian pair output stage.
- Takes a standard-deviation scale, a Box-Muller radius and a cos/sin pair, and produces two independent fixed-point Gaussian samples x = mu + sd·r·c and y = mu + sd·r·s.
- Includes rounding, saturation, valid/ready flow control and statistics counters.
- Sits between the uniform-to-radius/trig front end and downstream sample consumers.

---
 rtl/gauss_pair_scaler_if.sv | 45 ++++
 rtl/gauss_pair_scaler.sv | 258 +++++++++++++++++++++++++
 tb/tb_gauss_pair_scaler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gauss_pair_scaler_if.sv
// ---------------------------------------------------------------------------
// gauss_pair_scaler_if
//   Bundles the sample-set input stream, the x/y output stream and the
//   statistics counter signals of gauss_pair_scaler.
//
//   master : sample producer / consumer / counter reader side
//            (drives in_valid, sd, r, c, s, mu, out_ready, cnt_clr)
//   slave  : the scaler itself
//            (drives in_ready, out_valid, x, y, sat_x, sat_y,
//             sample_cnt, sat_cnt)
// ---------------------------------------------------------------------------
interface gauss_pair_scaler_if #(
  parameter int SD_W   = 16,
  parameter int R_W    = 16,
  parameter int TRIG_W = 16,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic        [SD_W-1:0]   sd;
  logic        [R_W-1:0]    r;
  logic signed [TRIG_W-1:0] c;
  logic signed [TRIG_W-1:0] s;
  logic signed [OUT_W-1:0]  mu;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  x;
  logic signed [OUT_W-1:0]  y;
  logic                     sat_x;
  logic                     sat_y;
  logic                     cnt_clr;
  logic        [CNT_W-1:0]  sample_cnt;
  logic        [CNT_W-1:0]  sat_cnt;

  modport master (
    output in_valid, sd, r, c, s, mu, out_ready, cnt_clr,
    input  in_ready, out_valid, x, y, sat_x, sat_y, sample_cnt, sat_cnt
  );

  modport slave (
    input  in_valid, sd, r, c, s, mu, out_ready, cnt_clr,
    output in_ready, out_valid, x, y, sat_x, sat_y, sample_cnt, sat_cnt
  );
endinterface

// File: rtl/gauss_pair_scaler.sv
// ---------------------------------------------------------------------------
// gauss_pair_scaler
//   Turns a Box-Muller radius r and a cos/sin pair (c, s) into two
//   fixed-point Gaussian samples:
//     x = mu + sd*r*c,  y = mu + sd*r*s
//   Three register stages (sd*r, times c/s, round+offset+saturate), one
//   pair per cycle, a single global enable so a downstream stall freezes
//   the whole pipeline.  Two statistics counters track transferred pairs
//   and transferred pairs with any clipped output.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        gauss_pair_scaler_if.slave:
//                in_valid/in_ready   input handshake (in_ready = enable)
//                sd, r               unsigned scale and radius
//                c, s, mu            signed cos, sin, mean offset
//                out_valid/out_ready output handshake
//                x, y                signed samples
//                sat_x, sat_y        clip flags for x, y
//                cnt_clr             synchronous clear of both counters
//                sample_cnt          transferred pairs (wraps)
//                sat_cnt             transferred clipped pairs (sticks at max)
// ---------------------------------------------------------------------------
module gauss_pair_scaler #(
  parameter int SD_W      = 16,
  parameter int SD_FRAC   = 8,
  parameter int R_W       = 16,
  parameter int R_FRAC    = 12,
  parameter int TRIG_W    = 16,
  parameter int TRIG_FRAC = 14,
  parameter int OUT_W     = 16,
  parameter int OUT_FRAC  = 8,
  parameter int CNT_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  gauss_pair_scaler_if.slave  bus
);

  // Product widths: sd*r is unsigned, times a signed trig value needs one
  // extra bit for the sign.  SUM_W leaves headroom for the rounding
  // constant and the mean offset so neither can wrap before saturation.
  localparam int P_W   = SD_W + R_W;
  localparam int PX_W  = P_W + TRIG_W + 1;
  localparam int SUM_W = PX_W + 2;
  // Binary point of px sits SH bits above the output binary point (SH >= 1).
  localparam int SH    = SD_FRAC + R_FRAC + TRIG_FRAC - OUT_FRAC;

  // -------------------------------------------------------------------------
  // Rounding / saturation helpers
  // -------------------------------------------------------------------------

  // Round half up, then arithmetic shift down to the output binary point.
  function automatic logic signed [SUM_W-1:0] round_shift(
    input logic signed [PX_W-1:0] v
  );
    logic signed [SUM_W-1:0] v_ext;
    logic signed [SUM_W-1:0] half;
    logic signed [SUM_W-1:0] sum;
    v_ext         = {{(SUM_W-PX_W){v[PX_W-1]}}, v};
    half          = '0;
    half[SH-1]    = 1'b1;
    sum           = v_ext + half;
    return sum >>> SH;
  endfunction

  // Clip to the OUT_W signed range; MSB of the result is the clip flag.
  function automatic logic [OUT_W:0] saturate(
    input logic signed [SUM_W-1:0] v
  );
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    hi            = '0;
    hi[OUT_W-2:0] = '1;
    lo            = '1;
    lo[OUT_W-2:0] = '0;
    if (v > hi) begin
      return {1'b1, hi[OUT_W-1:0]};
    end else if (v < lo) begin
      return {1'b1, lo[OUT_W-1:0]};
    end
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  // Full output path for one sample: round, add mean, saturate.
  function automatic logic [OUT_W:0] scale_out(
    input logic signed [PX_W-1:0]  prod,
    input logic signed [OUT_W-1:0] mean
  );
    logic signed [SUM_W-1:0] mean_ext;
    logic signed [SUM_W-1:0] total;
    mean_ext = {{(SUM_W-OUT_W){mean[OUT_W-1]}}, mean};
    total    = round_shift(prod) + mean_ext;
    return saturate(total);
  endfunction

  // -------------------------------------------------------------------------
  // Control: global enable and stage valids
  // -------------------------------------------------------------------------
  logic ce;
  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic vld_p3_q, vld_p3_d;
  logic xfer;

  assign ce           = !vld_p3_q || bus.out_ready;
  assign bus.in_ready = ce;
  assign xfer         = vld_p3_q && bus.out_ready;

  assign vld_p1_d = ce ? bus.in_valid : vld_p1_q;
  assign vld_p2_d = ce ? vld_p1_q     : vld_p2_q;
  assign vld_p3_d = ce ? vld_p2_q     : vld_p3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: p = sd * r
  // -------------------------------------------------------------------------
  logic        [P_W-1:0]    prod_d;
  logic        [P_W-1:0]    prod_p1_q;
  logic signed [TRIG_W-1:0] c_p1_q;
  logic signed [TRIG_W-1:0] s_p1_q;
  logic signed [OUT_W-1:0]  mu_p1_q;

  assign prod_d = {{R_W{1'b0}}, bus.sd} * {{SD_W{1'b0}}, bus.r};

  always_ff @(posedge clk) begin
    if (ce && bus.in_valid) begin
      prod_p1_q <= prod_d;
      c_p1_q    <= bus.c;
      s_p1_q    <= bus.s;
      mu_p1_q   <= bus.mu;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: px = p * c, py = p * s
  // -------------------------------------------------------------------------
  logic signed [PX_W-1:0]  p_ext;
  logic signed [PX_W-1:0]  c_ext;
  logic signed [PX_W-1:0]  s_ext;
  logic signed [PX_W-1:0]  px_d;
  logic signed [PX_W-1:0]  py_d;
  logic signed [PX_W-1:0]  px_p2_q;
  logic signed [PX_W-1:0]  py_p2_q;
  logic signed [OUT_W-1:0] mu_p2_q;

  // p is unsigned: zero-extend so it multiplies as a non-negative value.
  assign p_ext = {{(TRIG_W+1){1'b0}}, prod_p1_q};
  assign c_ext = {{(P_W+1){c_p1_q[TRIG_W-1]}}, c_p1_q};
  assign s_ext = {{(P_W+1){s_p1_q[TRIG_W-1]}}, s_p1_q};
  assign px_d  = p_ext * c_ext;
  assign py_d  = p_ext * s_ext;

  always_ff @(posedge clk) begin
    if (ce && vld_p1_q) begin
      px_p2_q <= px_d;
      py_p2_q <= py_d;
      mu_p2_q <= mu_p1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: round, add mean, saturate into the output register
  // -------------------------------------------------------------------------
  logic [OUT_W:0]          res_x;
  logic [OUT_W:0]          res_y;
  logic signed [OUT_W-1:0] x_q, x_d;
  logic signed [OUT_W-1:0] y_q, y_d;
  logic                    sat_x_q, sat_x_d;
  logic                    sat_y_q, sat_y_d;
  logic                    load_p3;

  assign res_x   = scale_out(px_p2_q, mu_p2_q);
  assign res_y   = scale_out(py_p2_q, mu_p2_q);
  // Output data only changes when a real sample arrives, so it stays
  // stable through stalls and bubbles.
  assign load_p3 = ce && vld_p2_q;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    sat_x_d = sat_x_q;
    sat_y_d = sat_y_q;
    if (load_p3) begin
      x_d     = res_x[OUT_W-1:0];
      y_d     = res_y[OUT_W-1:0];
      sat_x_d = res_x[OUT_W];
      sat_y_d = res_y[OUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      sat_x_q <= 1'b0;
      sat_y_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      sat_x_q <= sat_x_d;
      sat_y_q <= sat_y_d;
    end
  end

  assign bus.out_valid = vld_p3_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.sat_x     = sat_x_q;
  assign bus.sat_y     = sat_y_q;

  // -------------------------------------------------------------------------
  // Statistics counters
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  // Clear wins over a same-cycle transfer; sat_cnt sticks at all-ones.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    sat_cnt_d    = sat_cnt_q;
    if (bus.cnt_clr) begin
      sample_cnt_d = '0;
      sat_cnt_d    = '0;
    end else if (xfer) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if ((sat_x_q || sat_y_q) && (sat_cnt_q != '1)) begin
        sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt_q <= '0;
      sat_cnt_q    <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign bus.sample_cnt = sample_cnt_q;
  assign bus.sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_gauss_pair_scaler.sv
module tb_gauss_pair_scaler;

  logic clk;
  logic rst;

  gauss_pair_scaler_if #(
    .SD_W(16), .R_W(16), .TRIG_W(16), .OUT_W(16), .CNT_W(32)
  ) bus ();

  gauss_pair_scaler #(
    .SD_W(16), .SD_FRAC(8), .R_W(16), .R_FRAC(12), .TRIG_W(16),
    .TRIG_FRAC(14), .OUT_W(16), .OUT_FRAC(8), .CNT_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        sx;
    logic        sy;
    int          cyc;
  } item_t;

  item_t q[$];

  function automatic logic [31:0] u16(input logic [15:0] v);
    return {16'd0, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference for one sample: round half up at 2^26, add mean, clip to 16 bits.
  function automatic logic [16:0] ref_one(input logic [15:0] sd, input logic [15:0] r,
                                          input logic signed [15:0] t,
                                          input logic signed [15:0] mu);
    longint p, v;
    p = longint'(sd) * longint'(r);
    v = ((p * longint'(t) + (longint'(1) << 25)) >>> 26) + longint'(mu);
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  // Scoreboard side: every transfer pops and compares one expected pair.
  item_t       mon_it;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed pair x=0x%0h y=0x%0h, expected none", u16(bus.x), u16(bus.y));
      end
      if (q.size() != 0) begin
        mon_it = q.pop_front();
        chk("x", u16(bus.x), u16(mon_it.x));
        chk("y", u16(bus.y), u16(mon_it.y));
        chk("sat_x", {31'd0, bus.sat_x}, {31'd0, mon_it.sx});
        chk("sat_y", {31'd0, bus.sat_y}, {31'd0, mon_it.sy});
        if (mon_it.cyc >= 0) chk("latency", cyc, mon_it.cyc);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_one(input logic [15:0] sd, input logic [15:0] r,
                          input logic [15:0] c, input logic [15:0] s,
                          input logic [15:0] mu,
                          input logic [15:0] ex, input logic [15:0] ey,
                          input logic esx, input logic esy);
    item_t it;
    bus.sd = sd; bus.r = r; bus.c = c; bus.s = s; bus.mu = mu;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    it.x = ex; it.y = ey; it.sx = esx; it.sy = esy;
    it.cyc = cyc + 2;  // visible in the third cycle after the accept cycle
    q.push_back(it);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] sd_v, r_v, c_v, s_v, mu_v;
    logic [16:0] rx, ry;
    logic [15:0] hold_x, hold_y;
    logic        hold_sx, have_hold, acc;
    int          idx, stall_checks;
    item_t       it;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
    bus.sd = '0; bus.r = '0; bus.c = '0; bus.s = '0; bus.mu = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_x", u16(bus.x), 32'd0);
    chk("rst_y", u16(bus.y), 32'd0);
    chk("rst_sat", {30'd0, bus.sat_x, bus.sat_y}, 32'd0);
    chk("rst_sample_cnt", bus.sample_cnt, 32'd0);
    chk("rst_sat_cnt", bus.sat_cnt, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed single samples
    send_one(16'h0100, 16'h1000, 16'h4000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);
    drain();
    chk("unity_sample_cnt", bus.sample_cnt, 32'd1);
    send_one(16'h0100, 16'h1000, 16'h0020, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b0);
    drain();
    send_one(16'h0100, 16'h1000, 16'hFFE0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drain();
    send_one(16'h0100, 16'h1000, 16'hC000, 16'h4000, 16'h0100, 16'h0000, 16'h0200, 1'b0, 1'b0);
    drain();
    chk("pre_sat_cnt", bus.sat_cnt, 32'd0);
    send_one(16'hFFFF, 16'hFFFF, 16'h4000, 16'hC000, 16'h0000, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    drain();
    chk("sat_cnt_inc", bus.sat_cnt, 32'd1);
    send_one(16'h0000, 16'h1234, 16'h1111, 16'h2222, 16'hFF85, 16'hFF85, 16'hFF85, 1'b0, 1'b0);
    drain();
    send_one(16'h0100, 16'h0000, 16'h7FFF, 16'h8000, 16'h0042, 16'h0042, 16'h0042, 1'b0, 1'b0);
    drain();
    chk("sample_cnt_7", bus.sample_cnt, 32'd7);

    // Idle clear
    bus.cnt_clr = 1'b1;
    @(posedge clk); #1;
    bus.cnt_clr = 1'b0;
    chk("clr_sample_cnt", bus.sample_cnt, 32'd0);
    chk("clr_sat_cnt", bus.sat_cnt, 32'd0);

    // Stream of 8 with a 5-cycle downstream stall in the middle
    idx = 0; have_hold = 1'b0; stall_checks = 0;
    for (int k = 0; k < 60 && (idx < 8 || q.size() != 0); k++) begin
      bus.out_ready = !(k >= 6 && k < 11);
      if (idx < 8) begin
        sd_v = 16'($urandom_range(0, 16'h03FF)); r_v = 16'($urandom_range(0, 16'h3FFF));
        c_v = 16'($urandom); s_v = 16'($urandom); mu_v = 16'($urandom_range(0, 16'h0FFF) - 16'h0800);
        bus.sd = sd_v; bus.r = r_v; bus.c = c_v; bus.s = s_v; bus.mu = mu_v;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (!bus.out_ready && bus.out_valid) begin
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        if (have_hold) begin
          chk("stall_x", u16(bus.x), u16(hold_x));
          chk("stall_y", u16(bus.y), u16(hold_y));
          chk("stall_sat_x", {31'd0, bus.sat_x}, {31'd0, hold_sx});
          stall_checks++;
        end
        hold_x = bus.x; hold_y = bus.y; hold_sx = bus.sat_x; have_hold = 1'b1;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        rx = ref_one(sd_v, r_v, c_v, mu_v);
        ry = ref_one(sd_v, r_v, s_v, mu_v);
        it.x = rx[15:0]; it.y = ry[15:0]; it.sx = rx[16]; it.sy = ry[16]; it.cyc = -1;
        q.push_back(it);
        idx++;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("stream_accepted", idx, 32'd8);
    chk("stall_seen", stall_checks, 32'd4);
    drain();
    chk("stream_sample_cnt", bus.sample_cnt, 32'd8);

    // Reset with two pairs in flight
    bus.sd = 16'h0100; bus.r = 16'h1000; bus.c = 16'h4000; bus.s = 16'h4000; bus.mu = 16'h0000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.c = 16'h2000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_sample_cnt", bus.sample_cnt, 32'd0);
    chk("midrst_sat_cnt", bus.sat_cnt, 32'd0);
    q.delete();
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
    send_one(16'h0200, 16'h1000, 16'h4000, 16'hE000, 16'h0010, 16'h0210, 16'hFF10, 1'b0, 1'b0);
    drain();
    chk("post_rst_sample_cnt", bus.sample_cnt, 32'd1);

    // Clear coincident with a (saturated) output transfer
    send_one(16'hFFFF, 16'hFFFF, 16'h4000, 16'hC000, 16'h0000, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("clr_xfer_out_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.cnt_clr = 1'b1;
    @(posedge clk); #1;
    bus.cnt_clr = 1'b0;
    chk("clr_xfer_sample_cnt", bus.sample_cnt, 32'd0);
    chk("clr_xfer_sat_cnt", bus.sat_cnt, 32'd0);
    chk("clr_xfer_out_valid_after", {31'd0, bus.out_valid}, 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
